// File: rtl/knn_result_drain.sv
// Snapshots the TopK result array on query_done and streams its valid entries nearest-first over valid/ready.
// Optional: `define KNN_DRAIN_ORDER_CHECK_EN adds a sticky order_err output.
module knn_result_drain #(
   parameter int K         = 4,
   parameter int BIT_WIDTH = 8,
   parameter int CNT_W     = 16,
   parameter int ID_W      = 8,
   localparam int DIST_W   = 2 * BIT_WIDTH,
   localparam int ENTRY_W  = 1 + ID_W + DIST_W,
   localparam int IDX_W    = $clog2(K)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               query_done,
   input  logic [ENTRY_W-1:0] knn_in [K],
   input  logic [DIST_W-1:0]  threshold_in,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ENTRY_W-1:0] out_entry,
   output logic [IDX_W-1:0]   out_rank,
   output logic               out_last,
   output logic [DIST_W-1:0]  out_threshold,
   output logic [CNT_W-1:0]   query_count,
`ifdef KNN_DRAIN_ORDER_CHECK_EN
   output logic               order_err,
`endif
   output logic [CNT_W-1:0]   drop_count
);

   // Entry layout: {valid, id, dist}; valid is the MSB.
   typedef enum logic {IDLE, DRAIN} state_t;

   state_t             state;
   logic [ENTRY_W-1:0] snap [K];
   logic [K-1:0]       in_mask, snap_mask;
   logic [IDX_W:0]     in_first, in_after, nxt, nxt_after;
   logic               xfer, load;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Returns {found, index} of the lowest set mask bit at or above start.
   function automatic logic [IDX_W:0] find_from(input logic [K-1:0] mask, input int start);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = K - 1; i >= 0; i--)
         if (i >= start && mask[i]) r = {1'b1, IDX_W'(i)};
      return r;
   endfunction

   always_comb begin
      in_mask   = '0;
      snap_mask = '0;
      for (int i = 0; i < K; i++) begin
         in_mask[i]   = knn_in[i][ENTRY_W-1];
         snap_mask[i] = snap[i][ENTRY_W-1];
      end
      in_first  = find_from(in_mask, 0);
      in_after  = find_from(in_mask, int'(in_first[IDX_W-1:0]) + 1);
      nxt       = find_from(snap_mask, int'(out_rank) + 1);
      nxt_after = find_from(snap_mask, int'(nxt[IDX_W-1:0]) + 1);
   end

   assign xfer = out_valid & out_ready;
   // A pulse coinciding with the final transfer is a back-to-back capture, not a drop.
   assign load = query_done & ((state == IDLE) | (xfer & out_last));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         out_valid     <= 1'b0;
         out_entry     <= '0;
         out_rank      <= '0;
         out_last      <= 1'b0;
         out_threshold <= '0;
         query_count   <= '0;
         drop_count    <= '0;
         for (int i = 0; i < K; i++) snap[i] <= '0;
      end else begin
         if (load) begin
            state         <= DRAIN;
            busy          <= 1'b1;
            out_valid     <= 1'b1;
            out_threshold <= threshold_in;
            for (int i = 0; i < K; i++) snap[i] <= knn_in[i];
            if (in_first[IDX_W]) begin
               out_entry <= knn_in[in_first[IDX_W-1:0]];
               out_rank  <= in_first[IDX_W-1:0];
               out_last  <= ~in_after[IDX_W];
            end else begin
               out_entry <= knn_in[0];
               out_rank  <= '0;
               out_last  <= 1'b1;
            end
         end else if (xfer && out_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (xfer) begin
            out_entry <= snap[nxt[IDX_W-1:0]];
            out_rank  <= nxt[IDX_W-1:0];
            out_last  <= ~nxt_after[IDX_W];
         end

         if (xfer && out_last) query_count <= sat_inc(query_count);
         if (query_done && state == DRAIN && !(xfer && out_last))
            drop_count <= sat_inc(drop_count);
      end
   end

`ifdef KNN_DRAIN_ORDER_CHECK_EN
   logic [DIST_W-1:0] prev_dist;
   logic              prev_vld;
   logic [DIST_W-1:0] cur_dist;

   assign cur_dist = out_entry[DIST_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         order_err <= 1'b0;
         prev_dist <= '0;
         prev_vld  <= 1'b0;
      end else if (xfer) begin
         if (out_entry[ENTRY_W-1]) begin
            if ((prev_vld && cur_dist < prev_dist) || cur_dist > out_threshold)
               order_err <= 1'b1;
            prev_dist <= cur_dist;
         end
         prev_vld <= out_entry[ENTRY_W-1] & ~out_last;
      end
   end
`endif

endmodule

// File: tb/tb_knn_result_drain.sv
// Directed-vector bench for knn_result_drain (K=4, BIT_WIDTH=8, ID_W=8).
module tb_knn_result_drain;
   localparam int K = 4;
   localparam int ENTRY_W = 25;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               query_done = 1'b0;
   logic [ENTRY_W-1:0] knn_in [K];
   logic [15:0]        threshold_in = '0;
   logic               busy, out_valid, out_last;
   logic               out_ready = 1'b1;
   logic [ENTRY_W-1:0] out_entry;
   logic [1:0]         out_rank;
   logic [15:0]        out_threshold, query_count, drop_count;
`ifdef KNN_DRAIN_ORDER_CHECK_EN
   logic               order_err;
`endif

   int checks = 0;
   int failures = 0;

   knn_result_drain #(.K(K), .BIT_WIDTH(8), .CNT_W(16), .ID_W(8)) dut (
      .clk(clk), .reset(reset), .query_done(query_done), .knn_in(knn_in),
      .threshold_in(threshold_in), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_entry(out_entry), .out_rank(out_rank), .out_last(out_last),
      .out_threshold(out_threshold), .query_count(query_count),
`ifdef KNN_DRAIN_ORDER_CHECK_EN
      .order_err(order_err),
`endif
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [ENTRY_W-1:0] mk(input logic v, input int id, input int d);
      return {v, 8'(id), 16'(d)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_q(input int d0, input int d1, input int d2, input int d3, input logic [3:0] m);
      knn_in[0] = mk(m[0], 10, d0);
      knn_in[1] = mk(m[1], 11, d1);
      knn_in[2] = mk(m[2], 12, d2);
      knn_in[3] = mk(m[3], 13, d3);
   endtask

   task automatic chk_beat(input string tag, input int rank, input logic v, input int d, input logic last);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_rank"},  64'(out_rank), 64'(rank));
      chk({tag, "_entry"}, 64'(out_entry), 64'(mk(v, 10 + rank, d)));
      chk({tag, "_last"},  64'(out_last), 64'(last));
   endtask

   task automatic chk_idle(input string tag, input int qc);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_qcnt"},  64'(query_count), 64'(qc));
   endtask

   task automatic pulse_query();
      query_done = 1'b1;
      step();
      query_done = 1'b0;
   endtask

   initial begin
      set_q(0, 0, 0, 0, 4'b0000);
      #2 reset = 1'b1;
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_entry", 64'(out_entry), 64'd0);
      chk("rst_qcnt", 64'(query_count), 64'd0);
      chk("rst_dcnt", 64'(drop_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // All valid, continuous ready
      set_q(3, 5, 9, 12, 4'b1111);
      threshold_in = 16'd20;
      pulse_query();
      chk_beat("all_r0", 0, 1'b1, 3, 1'b0);
      chk("all_busy", 64'(busy), 64'd1);
      chk("all_thr", 64'(out_threshold), 64'd20);
      step(); chk_beat("all_r1", 1, 1'b1, 5, 1'b0);
      step(); chk_beat("all_r2", 2, 1'b1, 9, 1'b0);
      step(); chk_beat("all_r3", 3, 1'b1, 12, 1'b1);
      step(); chk_idle("all_end", 1);

      // Sparse mask: only idx 0 and 2
      set_q(4, 6, 8, 10, 4'b0101);
      pulse_query();
      chk_beat("msk_r0", 0, 1'b1, 4, 1'b0);
      step(); chk_beat("msk_r2", 2, 1'b1, 8, 1'b1);
      step(); chk_idle("msk_end", 2);

      // Empty query
      set_q(7, 6, 5, 4, 4'b0000);
      pulse_query();
      chk_beat("emp", 0, 1'b0, 7, 1'b1);
      step(); chk_idle("emp_end", 3);

      // Backpressure on rank 1 for five cycles
      set_q(3, 5, 9, 12, 4'b1111);
      pulse_query();
      chk_beat("bp_r0", 0, 1'b1, 3, 1'b0);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_beat("bp_hold", 1, 1'b1, 5, 1'b0);
         chk("bp_thr", 64'(out_threshold), 64'd20);
         step();
      end
      chk_beat("bp_hold_end", 1, 1'b1, 5, 1'b0);
      out_ready = 1'b1;
      step(); chk_beat("bp_r2", 2, 1'b1, 9, 1'b0);
      step(); chk_beat("bp_r3", 3, 1'b1, 12, 1'b1);
      step(); chk_idle("bp_end", 4);

      // Two dropped pulses, then a back-to-back capture on the last transfer
      set_q(3, 5, 9, 12, 4'b1111);
      pulse_query();
      chk_beat("drp_r0", 0, 1'b1, 3, 1'b0);
      set_q(1, 2, 50, 60, 4'b0011);
      threshold_in = 16'd30;
      pulse_query();
      chk_beat("drp_r1", 1, 1'b1, 5, 1'b0);
      pulse_query();
      chk_beat("drp_r2", 2, 1'b1, 9, 1'b0);
      chk("drp_dcnt", 64'(drop_count), 64'd2);
      step();
      chk_beat("drp_r3", 3, 1'b1, 12, 1'b1);
      chk("drp_thr_old", 64'(out_threshold), 64'd20);
      pulse_query();
      chk_beat("b2b_r0", 0, 1'b1, 1, 1'b0);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_qcnt", 64'(query_count), 64'd5);
      chk("b2b_dcnt", 64'(drop_count), 64'd2);
      chk("b2b_thr", 64'(out_threshold), 64'd30);
      step(); chk_beat("b2b_r1", 1, 1'b1, 2, 1'b1);
      step(); chk_idle("b2b_end", 6);

      // Async reset mid-drain
      set_q(3, 5, 9, 12, 4'b1111);
      threshold_in = 16'd20;
      pulse_query();
      step();
      chk_beat("ar_r1", 1, 1'b1, 5, 1'b0);
      #1 reset = 1'b1;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_entry", 64'(out_entry), 64'd0);
      chk("ar_last", 64'(out_last), 64'd0);
      chk("ar_rank", 64'(out_rank), 64'd0);
      chk("ar_thr", 64'(out_threshold), 64'd0);
      chk("ar_qcnt", 64'(query_count), 64'd0);
      chk("ar_dcnt", 64'(drop_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      chk_idle("ar_after", 0);

`ifdef KNN_DRAIN_ORDER_CHECK_EN
      set_q(3, 9, 5, 12, 4'b1111);
      pulse_query();
      chk("oe_r0", 64'(order_err), 64'd0);
      step(); chk("oe_r1", 64'(order_err), 64'd0);
      step(); chk("oe_r2", 64'(order_err), 64'd0);
      step(); chk("oe_r3", 64'(order_err), 64'd1);
      step(); chk("oe_sticky", 64'(order_err), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
